aud_player: RTL
===============

Name: aud_player

Overview:
- Playback counterpart of the audio recorder. Reads 16-bit samples from SRAM and serialises them MSB-first onto the codec DAC data line, timed by the codec bit clock and DAC LR clock.
- Each stored sample is sent on both left and right channels (mono).
- Sits between the SRAM arbiter (read port) and the WM8731 DACDAT pin. It is driven by the same start/pause/stop controls as the recorder.

Parameters:
- ADDR_W, 20, SRAM word-address width
- SAMPLE_W, 16, bits per sample and per channel slot

Ports:
- i_clk  in  1  codec bit clock (AUD_BCLK); all logic on posedge
- i_rst_n  in  1  synchronous, active-low reset
- i_lrc  in  1  DAC LR clock (AUD_DACLRCK); low = left, high = right
- i_start  in  1  start from address 0 when stopped; resume when paused
- i_pause  in  1  pause playback
- i_stop  in  1  stop playback, rewind to 0
- i_end_addr  in  ADDR_W  last valid sample address (inclusive)
- i_rd_data  in  SAMPLE_W  SRAM read data for o_address (combinational, valid same cycle)
- o_address  out  ADDR_W  SRAM read address
- o_dac_data  out  1  serial DAC data
- o_state  out  3  current FSM state, zero-extended
- o_fin  out  1  one-cycle pulse when the end address finishes playing

Behaviour:
- Reset is synchronous, active-low, and sampled on posedge i_clk. On reset:
  - o_address=0, o_dac_data=0, o_fin=0, state=STOPPED.
  - lrc_p=0, shift register=0, bit counter=0, channel flag=left.
- LRC edges:
  - lrc_p is i_lrc registered every cycle.
  - Falling edge (FE): lrc_p=1 and i_lrc=0, giving a left slot.
  - Rising edge (RE): lrc_p=0 and i_lrc=1, giving a right slot.
- States: STOPPED=0, PAUSE=1, PLAYING=2, WAITING=3.
- Control priority in every state: i_stop > i_pause > i_start.
- STOPPED:
  - o_dac_data=0 and o_fin=0.
  - On i_start: o_address←0 and go to WAITING.
- WAITING:
  - i_stop → STOPPED with o_address←0.
  - i_pause → PAUSE.
  - FE → load shift reg ← i_rd_data, counter←0, channel=left, go to PLAYING.
  - RE is ignored while the channel flag is left-pending; playback always starts on a left slot.
  - RE with channel flag = right-pending → load shift reg ← i_rd_data (same address), go to PLAYING.
- PLAYING:
  - In the cycles after entry, o_dac_data presents bit SAMPLE_W-1 down to bit 0, one bit per cycle.
  - First bit is registered on the cycle after the edge-detect cycle E. Bit k appears at E+SAMPLE_W-k. After SAMPLE_W bits, o_dac_data=0.
  - Left word done → channel flag = right-pending, go to WAITING. Address is unchanged.
  - Right word done and o_address==i_end_addr → o_fin=1 for one cycle, o_address←0, go to STOPPED.
  - Right word done otherwise → o_address←o_address+1, channel flag = left-pending, go to WAITING.
  - i_stop mid-word → STOPPED immediately: o_dac_data=0, o_address←0, o_fin stays 0.
  - i_pause mid-word → PAUSE immediately: o_dac_data=0, address held, partial word discarded, channel flag ← left-pending.
- PAUSE:
  - o_dac_data=0 and address held.
  - i_start → WAITING; the same sample is replayed from its left slot.
  - i_stop → STOPPED with o_address←0.
- Boundaries:
  - i_end_addr=0 plays exactly one sample.
  - Address wraps to 0 only through the end or stop paths; incrementing past the ADDR_W max never occurs while i_end_addr ≤ max.
  - An edge that arrives in the same cycle as i_stop or i_pause is ignored.
  - i_start while in WAITING or PLAYING is ignored.
  - Changing i_end_addr mid-play takes effect at the next right-word completion.
  - Reset asserted mid-word aborts immediately.

Optional Feature:
- Macro: AUD_PLAYER_LOOP_EN.
- Defined: at right-word completion with o_address==i_end_addr, pulse o_fin for one cycle, set o_address←0 and go to WAITING (continuous loop). Only i_stop or i_pause exits.
- Undefined: stop-at-end behaviour as described in Behaviour.

Decomposition:
- Shared package aud_pkg:
  - state enum (STOPPED/PAUSE/PLAYING/WAITING, 2-bit encoding, identical to the recorder's);
  - ADDR_W and SAMPLE_W defaults;
  - channel enum (LEFT/RIGHT).
- One sub-module: aud_serializer, a parallel-in serial-out shift register with load, shift-enable, clear and done flag. The FSM and address logic stay in aud_player.

Test Plan:
- Reset, then i_start; SRAM[0]=16'hA5C3, i_end_addr=0 → bits 1010_0101_1100_0011 appear at E+1..E+16 after the FE. The same bits repeat after the next RE. o_fin pulses once, state returns to STOPPED (0) and o_address=0.
- SRAM[0..2]=16'h0001, 16'h8000, 16'hFFFF, i_end_addr=2 → each word is sent twice (L/R). o_address steps 0→1→2 only after right words complete. o_fin fires after the second 16'hFFFF word.
- i_pause at bit 5 of the right slot of address 1 → o_dac_data=0 next cycle, o_state=1, o_address=1. i_start later → address 1 replays from its next left slot.
- i_stop and i_pause asserted in the same cycle mid-word → state STOPPED, o_address=0, o_fin=0.
- i_start asserted while i_lrc is high (right slot) → no data until the first FE. o_dac_data stays 0 through the RE.
- With AUD_PLAYER_LOOP_EN defined and i_end_addr=1 → play order is 0,1,0,1 with an o_fin pulse after each address-1 right word. State never reaches STOPPED until i_stop.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared types for the audio recorder/player pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aud_pkg;

    // Default widths; modules take these as parameter defaults.
    localparam int AUD_ADDR_W   = 20;
    localparam int AUD_SAMPLE_W = 16;

    // Same 2-bit encoding as the recorder so both report identical o_state codes.
    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        PAUSE   = 2'd1,
        PLAYING = 2'd2,
        WAITING = 2'd3
    } aud_state_e;

    // Channel slot that is pending / being played.
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } aud_chan_e;

endpackage

// File: rtl/aud_serializer.sv
// Parallel-in serial-out shift register, MSB first, with load / shift / clear.
// Latency: loaded MSB is visible on o_ser_dat the cycle after i_load; one bit per i_shift_en.
// Backpressure: none; the caller gates shifting with i_shift_en. o_done marks the last bit.
// Ports: i_clk, i_rst_n (sync, active-low), i_load/i_load_dat, i_shift_en, i_clr,
//        o_ser_dat (current bit), o_done (last bit of the word is on o_ser_dat).
module aud_serializer
    import aud_pkg::*;
#(
    parameter int SAMPLE_W = AUD_SAMPLE_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [SAMPLE_W-1:0] i_load_dat,
    input  logic                i_shift_en,
    input  logic                i_clr,
    output logic                o_ser_dat,
    output logic                o_done
);

    localparam int                CNT_W    = $clog2(SAMPLE_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_W - 1);

    logic [SAMPLE_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    assign o_ser_dat = sr_q[SAMPLE_W-1];
    assign o_done    = (cnt_q == CNT_LAST);

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (i_clr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (i_load) begin
            sr_d  = i_load_dat;
            cnt_d = '0;
        end else if (i_shift_en) begin
            // Zero fill: once the word is out the line idles low by itself.
            sr_d  = {sr_q[SAMPLE_W-2:0], 1'b0};
            cnt_d = o_done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aud_player.sv
// Audio player: reads SRAM samples and serialises each one onto DACDAT for left then right slot.
// Latency: first bit one cycle after the LRC edge-detect cycle; SAMPLE_W bits per slot.
// Backpressure: none; pacing comes from i_lrc edges, controls are start/pause/stop.
// Ports: i_clk (BCLK), i_rst_n (sync, active-low), i_lrc, i_start/i_pause/i_stop,
//        i_end_addr, i_rd_data -> o_address, o_dac_data, o_state, o_fin.
// Build option: define AUD_PLAYER_LOOP_EN to loop back to address 0 after the end address
//        instead of stopping.
module aud_player
    import aud_pkg::*;
#(
    parameter int ADDR_W   = AUD_ADDR_W,
    parameter int SAMPLE_W = AUD_SAMPLE_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_lrc,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    input  logic [ADDR_W-1:0]   i_end_addr,
    input  logic [SAMPLE_W-1:0] i_rd_data,
    output logic [ADDR_W-1:0]   o_address,
    output logic                o_dac_data,
    output logic [2:0]          o_state,
    output logic                o_fin
);

    aud_state_e          state_q, state_d;
    aud_chan_e           chan_q, chan_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                lrc_p_q, lrc_p_d;

    logic fe, re, at_end;
    logic ser_load, ser_shift, ser_clr, ser_done, ser_dat;
    logic fin;

    assign lrc_p_d = i_lrc;
    assign fe      = lrc_p_q & ~i_lrc;
    assign re      = ~lrc_p_q & i_lrc;
    assign at_end  = (addr_q == i_end_addr);

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        addr_d    = addr_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        ser_clr   = 1'b0;
        fin       = 1'b0;

        case (state_q)
            STOPPED: begin
                if (!i_stop && !i_pause && i_start) begin
                    addr_d  = '0;
                    chan_d  = LEFT;
                    state_d = WAITING;
                end
            end

            WAITING: begin
                if (i_stop) begin
                    addr_d  = '0;
                    state_d = STOPPED;
                end else if (i_pause) begin
                    chan_d  = LEFT;
                    state_d = PAUSE;
                end else if (fe) begin
                    // A left slot always restarts the sample, even if its right slot was missed.
                    ser_load = 1'b1;
                    chan_d   = LEFT;
                    state_d  = PLAYING;
                end else if (re && chan_q == RIGHT) begin
                    ser_load = 1'b1;
                    state_d  = PLAYING;
                end
            end

            PLAYING: begin
                if (i_stop) begin
                    ser_clr = 1'b1;
                    addr_d  = '0;
                    state_d = STOPPED;
                end else if (i_pause) begin
                    // Partial word is dropped; resume replays the sample from its left slot.
                    ser_clr = 1'b1;
                    chan_d  = LEFT;
                    state_d = PAUSE;
                end else begin
                    ser_shift = 1'b1;
                    if (ser_done) begin
                        if (chan_q == LEFT) begin
                            chan_d  = RIGHT;
                            state_d = WAITING;
                        end else if (at_end) begin
                            fin    = 1'b1;
                            addr_d = '0;
                            chan_d = LEFT;
`ifdef AUD_PLAYER_LOOP_EN
                            state_d = WAITING;
`else
                            state_d = STOPPED;
`endif
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            chan_d  = LEFT;
                            state_d = WAITING;
                        end
                    end
                end
            end

            PAUSE: begin
                if (i_stop) begin
                    addr_d  = '0;
                    state_d = STOPPED;
                end else if (!i_pause && i_start) begin
                    state_d = WAITING;
                end
            end

            default: begin
                addr_d  = '0;
                chan_d  = LEFT;
                state_d = STOPPED;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= STOPPED;
            chan_q  <= LEFT;
            addr_q  <= '0;
            lrc_p_q <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            addr_q  <= addr_d;
            lrc_p_q <= lrc_p_d;
        end
    end

    aud_serializer #(
        .SAMPLE_W (SAMPLE_W)
    ) u_ser (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (ser_load),
        .i_load_dat (i_rd_data),
        .i_shift_en (ser_shift),
        .i_clr      (ser_clr),
        .o_ser_dat  (ser_dat),
        .o_done     (ser_done)
    );

    assign o_address  = addr_q;
    assign o_dac_data = ser_dat;
    assign o_state    = {1'b0, state_q};
    assign o_fin      = fin;

endmodule
